// File: rtl/nts_tx_arbiter_pkg.sv
// nts_tx_arbiter_pkg: FSM encoding, default sizing and byte-mask width helper for the TX arbiter
package nts_tx_arbiter_pkg;
   typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_STREAM, ST_DRAIN, ST_GAP} state_t;
   localparam int DEF_MAC_DATA_WIDTH     = 64;
   localparam int DEF_IFG_CYCLES         = 2;
   localparam int DEF_FIRST_WORD_TIMEOUT = 16;
   localparam int DEF_MAX_WORDS          = 190;
   function automatic int valid_width(input int data_width);
      return data_width / 8;
   endfunction
endpackage

// File: rtl/nts_tx_rr_arbiter.sv
// nts_tx_rr_arbiter: two-requester round-robin; the registered grant doubles as the last-granted pointer
module nts_tx_rr_arbiter (
   input  logic       i_clk,
   input  logic       i_areset,
   input  logic [1:0] i_req,
   input  logic       i_freeze,
   output logic       o_gnt
);
   logic pick;
   assign pick = (&i_req) ? !o_gnt : i_req[1];
   always_ff @(posedge i_clk) begin
      if (i_areset) o_gnt <= 1'b1;
      else if (!i_freeze && |i_req) o_gnt <= pick;
   end
endmodule

// File: rtl/nts_tx_arbiter.sv
// nts_tx_arbiter: grants one of two TX sources to the MAC, forwards its frame and enforces gap, timeout and size limits
module nts_tx_arbiter
   import nts_tx_arbiter_pkg::*;
#(
   parameter int MAC_DATA_WIDTH     = DEF_MAC_DATA_WIDTH,
   parameter int IFG_CYCLES         = DEF_IFG_CYCLES,
   parameter int FIRST_WORD_TIMEOUT = DEF_FIRST_WORD_TIMEOUT,
   parameter int MAX_WORDS          = DEF_MAX_WORDS
) (
   input  logic                                     i_clk,
   input  logic                                     i_areset,
   input  logic                                     i_s0_tx_start,
   output logic                                     o_s0_tx_ack,
   input  logic [valid_width(MAC_DATA_WIDTH)-1:0]   i_s0_tx_data_valid,
   input  logic [MAC_DATA_WIDTH-1:0]                i_s0_tx_data,
   input  logic                                     i_s1_tx_start,
   output logic                                     o_s1_tx_ack,
   input  logic [valid_width(MAC_DATA_WIDTH)-1:0]   i_s1_tx_data_valid,
   input  logic [MAC_DATA_WIDTH-1:0]                i_s1_tx_data,
   output logic                                     o_mac_tx_start,
   input  logic                                     i_mac_tx_ack,
   output logic [valid_width(MAC_DATA_WIDTH)-1:0]   o_mac_tx_data_valid,
   output logic [MAC_DATA_WIDTH-1:0]                o_mac_tx_data,
   output logic [31:0]                              o_frames_s0,
   output logic [31:0]                              o_frames_s1,
   output logic [15:0]                              o_errors
);
   localparam int DVW = valid_width(MAC_DATA_WIDTH);
   localparam int WW  = $clog2(MAX_WORDS + 1);
   localparam int TW  = $clog2(FIRST_WORD_TIMEOUT + 1);
   localparam int GW  = $clog2(IFG_CYCLES + 1);
   state_t                    state;
   logic                      gnt;
   logic                      src_start;
   logic [DVW-1:0]            src_valid;
   logic [MAC_DATA_WIDTH-1:0] src_data;
   logic [WW-1:0]             words;
   logic [TW-1:0]             wait_cnt;
   logic [GW-1:0]             gap_cnt;
   logic [15:0]               err_next;
   assign src_start = gnt ? i_s1_tx_start : i_s0_tx_start;
   assign src_valid = gnt ? i_s1_tx_data_valid : i_s0_tx_data_valid;
   assign src_data  = gnt ? i_s1_tx_data : i_s0_tx_data;
   assign err_next  = (o_errors == 16'hFFFF) ? o_errors : o_errors + 16'd1;
   nts_tx_rr_arbiter u_rr (
      .i_clk    (i_clk),
      .i_areset (i_areset),
      .i_req    ({i_s1_tx_start, i_s0_tx_start}),
      .i_freeze (state != ST_IDLE),
      .o_gnt    (gnt)
   );
   always_ff @(posedge i_clk) begin
      if (i_areset) begin
         state               <= ST_IDLE;
         o_s0_tx_ack         <= 1'b0;
         o_s1_tx_ack         <= 1'b0;
         o_mac_tx_start      <= 1'b0;
         o_mac_tx_data_valid <= '0;
         o_mac_tx_data       <= '0;
         o_frames_s0         <= '0;
         o_frames_s1         <= '0;
         o_errors            <= '0;
         words               <= '0;
         wait_cnt            <= '0;
         gap_cnt             <= '0;
      end else begin
         o_s0_tx_ack         <= 1'b0;
         o_s1_tx_ack         <= 1'b0;
         o_mac_tx_data_valid <= '0;
         o_mac_tx_data       <= '0;
         case (state)
            ST_IDLE: if (i_s0_tx_start || i_s1_tx_start) begin
               state          <= ST_REQ;
               o_mac_tx_start <= 1'b1;
            end
            ST_REQ: if (i_mac_tx_ack) begin
               state          <= ST_STREAM;
               o_mac_tx_start <= 1'b0;
               o_s0_tx_ack    <= !gnt;
               o_s1_tx_ack    <= gnt;
               words          <= '0;
               wait_cnt       <= '0;
            end else if (!src_start) begin
               state          <= ST_IDLE;
               o_mac_tx_start <= 1'b0;
            end
            ST_STREAM: if (src_valid == '0) begin
               if (words != '0) begin
                  state   <= ST_GAP;
                  gap_cnt <= '0;
                  if (gnt) o_frames_s1 <= o_frames_s1 + 32'd1;
                  else o_frames_s0 <= o_frames_s0 + 32'd1;
               end else if (wait_cnt == TW'(FIRST_WORD_TIMEOUT - 1)) begin
                  state    <= ST_GAP;
                  gap_cnt  <= '0;
                  o_errors <= err_next;
               end else wait_cnt <= wait_cnt + 1'b1;
            end else if (words == WW'(MAX_WORDS)) begin
               // runaway frame: swallow the excess word and everything after it
               state    <= ST_DRAIN;
               o_errors <= err_next;
            end else begin
               words               <= words + 1'b1;
               o_mac_tx_data_valid <= src_valid;
               o_mac_tx_data       <= src_data;
            end
            ST_DRAIN: if (src_valid == '0) begin
               state   <= ST_GAP;
               gap_cnt <= '0;
            end
            ST_GAP: if (gap_cnt == GW'(IFG_CYCLES - 1)) state <= ST_IDLE;
               else gap_cnt <= gap_cnt + 1'b1;
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule
